cl_ddr_rd_arb: RTL and testbench
================================

CL_DDR_RD_ARB -- requirements
Module: cl_ddr_rd_arb

Interface
REQ-001 SHALL have parameter MAX_OUT, default 8, giving the maximum outstanding read bursts per source (range 1..63).
REQ-002 SHALL have parameter DATA_W, default 512, giving the R data width.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s0_arvalid and s1_arvalid, input, 1 bit each: source AR request (s0 = PCIS DMA, s1 = CL AXI master).
REQ-006 SHALL have ports s0_arready and s1_arready, output, 1 bit each: source AR accept.
REQ-007 SHALL have ports s0_arid and s1_arid, input, 6 bits each: source AR ID.
REQ-008 SHALL have ports s0_araddr and s1_araddr, input, 64 bits each: source AR address.
REQ-009 SHALL have ports s0_arlen/s1_arlen (input, 8 bits each) and s0_arsize/s1_arsize (input, 3 bits each): source AR burst length and size.
REQ-010 SHALL have ports s0_rvalid/s1_rvalid (output, 1), s0_rready/s1_rready (input, 1), s0_rid/s1_rid (output, 6), s0_rdata/s1_rdata (output, DATA_W), s0_rresp/s1_rresp (output, 2) and s0_rlast/s1_rlast (output, 1): the source R channels.
REQ-011 SHALL have ports m_arvalid (output, 1), m_arready (input, 1), m_arid (output, 7), m_araddr (output, 64), m_arlen (output, 8) and m_arsize (output, 3): the DDR-side AR channel.
REQ-012 SHALL have ports m_rvalid (input, 1), m_rready (output, 1), m_rid (input, 7), m_rdata (input, DATA_W), m_rresp (input, 2) and m_rlast (input, 1): the DDR-side R channel.
REQ-013 SHALL have ports s0_out_cnt and s1_out_cnt, output, 6 bits each: outstanding-burst counts.
REQ-014 SHALL have port rd_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 SHALL implement a two-state FSM: IDLE -> HOLD on a source AR handshake; HOLD -> IDLE on an m_arvalid && m_arready handshake.
REQ-016 SHALL treat source N as eligible when sN_arvalid=1 and sN_out_cnt < MAX_OUT.
REQ-017 SHALL, in IDLE, grant round-robin among eligible sources: a single eligible source wins; when both are eligible, the source not granted last wins.
REQ-018 SHALL, in IDLE, drive sN_arready combinationally equal to grant_N, so at most one sN_arready is high; both sN_arready SHALL be 0 in HOLD.
REQ-019 SHALL, on a source handshake, register {N, sN_arid}, addr, len and size, and drive m_arvalid=1 from the next cycle until m_arready; the AR fields SHALL stay stable while m_arvalid=1.
REQ-020 SHALL give a latency of one cycle from source handshake to m_arvalid, and a peak AR throughput of one burst per 2 cycles.
REQ-021 SHALL route the R channel combinationally on m_rid[6]: the selected sN_rvalid = m_rvalid, sN_rid = m_rid[5:0], and rdata/rresp/rlast pass through; the unselected sN_rvalid = 0; m_rready = sN_rready of the selected source.
REQ-022 SHALL increment sN_out_cnt on a source-N AR handshake and decrement it on a source-N R handshake with rlast=1; when both occur in the same cycle, the count SHALL be unchanged.
REQ-023 SHALL never let a counter exceed MAX_OUT; at MAX_OUT the source is ineligible and the other source may still be granted.
REQ-024 SHALL, on an rlast handshake for a source whose count is 0, hold the count at 0 and set rd_err=1; rd_err SHALL stay 1 until reset.
REQ-025 SHALL keep sN_arready=0 while m_arready is stalled in HOLD, with no request loss or reordering per source.

Reset
REQ-026 SHALL, on aresetn=0, immediately and asynchronously force: FSM=IDLE, m_arvalid=0, both counters=0, rd_err=0, and the last-grant pointer=s1 (so s0 wins the first tie).
REQ-027 SHALL drop an in-flight HOLD request when reset is asserted mid-operation; sources re-issue after reset.
REQ-028 SHALL keep the R routing active during reset (it is combinational); an rlast beat arriving with counters at 0 after reset deassertion SHALL set rd_err per REQ-024.

Verification
REQ-029 Tie: s0 and s1 arvalid both high from reset, m_arready=1 -> grants s0, s1, s0, s1; m_arid[6] = 0,1,0,1; one AR every 2 cycles.
REQ-030 Stall: hold m_arready=0 for 5 cycles in HOLD -> m_arvalid and all AR fields stable, both sN_arready=0; AR completes on the cycle m_arready=1.
REQ-031 Limit: MAX_OUT=8, s1 issues 8 bursts with no R returned -> s1_out_cnt=8, s1 is blocked, and s0 is still granted; one s1 rlast beat -> count 7 and s1 granted again.
REQ-032 Simultaneous: s0 AR handshake and s0 rlast handshake in the same cycle with count 3 -> count stays 3.
REQ-033 Error: m_rid=7'h40, rlast=1, handshake with s1_out_cnt=0 -> rd_err=1, count 0, beat routed to s1; rd_err is cleared only by aresetn=0.
REQ-034 Mid-op reset: aresetn=0 while in HOLD -> m_arvalid=0 in the same cycle, counters 0; after release, the first tie is granted to s0.

Source files
------------

// File: rtl/cl_ddr_rd_arb.sv
// Two-source AXI read arbiter in front of a single DDR read port.
// Sources are granted round-robin, the winning AR is re-issued from a holding register, and R beats are steered back by m_rid[6].
module cl_ddr_rd_arb #(
  parameter int MAX_OUT = 8,
  parameter int DATA_W  = 512
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [5:0]        s0_arid,
  input  logic [63:0]       s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [5:0]        s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,

  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [5:0]        s1_arid,
  input  logic [63:0]       s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [5:0]        s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,

  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [6:0]        m_arid,
  output logic [63:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [6:0]        m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,

  output logic [5:0]        s0_out_cnt,
  output logic [5:0]        s1_out_cnt,
  output logic              rd_err
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic [5:0] MAX_CNT = 6'(MAX_OUT);

  state_e      state_q, state_d;
  logic        last_q, last_d;      // 1: s1 was granted most recently
  logic [6:0]  arid_q, arid_d;
  logic [63:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [5:0]  cnt0_q, cnt0_d;
  logic [5:0]  cnt1_q, cnt1_d;
  logic        rd_err_q, rd_err_d;

  logic elig0, elig1, grant0, grant1;
  logic rsel, rlast_hs0, rlast_hs1;

  // R channel is purely combinational so it keeps routing through reset.
  assign rsel      = m_rid[6];
  assign s0_rvalid = m_rvalid & ~rsel;
  assign s1_rvalid = m_rvalid &  rsel;
  assign s0_rid    = m_rid[5:0];
  assign s1_rid    = m_rid[5:0];
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign m_rready  = rsel ? s1_rready : s0_rready;

  assign rlast_hs0 = m_rvalid & m_rready & m_rlast & ~rsel;
  assign rlast_hs1 = m_rvalid & m_rready & m_rlast &  rsel;

  assign elig0 = s0_arvalid && (cnt0_q < MAX_CNT);
  assign elig1 = s1_arvalid && (cnt1_q < MAX_CNT);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (elig0 && elig1) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign s0_arready = grant0;
  assign s1_arready = grant1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          state_d  = HOLD;
          last_d   = 1'b0;
          arid_d   = {1'b0, s0_arid};
          araddr_d = s0_araddr;
          arlen_d  = s0_arlen;
          arsize_d = s0_arsize;
        end else if (grant1) begin
          state_d  = HOLD;
          last_d   = 1'b1;
          arid_d   = {1'b1, s1_arid};
          araddr_d = s1_araddr;
          arlen_d  = s1_arlen;
          arsize_d = s1_arsize;
        end
      end
      HOLD: if (m_arready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An AR and a final R beat in the same cycle cancel; a final beat against an empty count is a protocol error.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0 && !rlast_hs0)                         cnt0_d = cnt0_q + 6'd1;
    else if (rlast_hs0 && !grant0 && cnt0_q != 6'd0)  cnt0_d = cnt0_q - 6'd1;
    if (grant1 && !rlast_hs1)                         cnt1_d = cnt1_q + 6'd1;
    else if (rlast_hs1 && !grant1 && cnt1_q != 6'd0)  cnt1_d = cnt1_q - 6'd1;
    rd_err_d = rd_err_q
             | (rlast_hs0 && cnt0_q == 6'd0)
             | (rlast_hs1 && cnt1_q == 6'd0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of its peers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign m_arvalid  = (state_q == HOLD);
  assign m_arid     = arid_q;
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = arsize_q;
  assign s0_out_cnt = cnt0_q;
  assign s1_out_cnt = cnt1_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_cl_ddr_rd_arb.sv
// Self-checking bench for cl_ddr_rd_arb: a cycle model predicts grants, counters and rd_err,
// and a scoreboard queue holds the ARs expected on the DDR side in issue order.
module tb_cl_ddr_rd_arb;

  localparam int MAX_OUT = 8;
  localparam int DATA_W  = 512;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  logic              s0_arvalid = 0, s1_arvalid = 0;
  logic              s0_arready, s1_arready;
  logic [5:0]        s0_arid = 0, s1_arid = 0;
  logic [63:0]       s0_araddr = 0, s1_araddr = 0;
  logic [7:0]        s0_arlen = 0, s1_arlen = 0;
  logic [2:0]        s0_arsize = 0, s1_arsize = 0;
  logic              s0_rvalid, s1_rvalid;
  logic              s0_rready = 1, s1_rready = 1;
  logic [5:0]        s0_rid, s1_rid;
  logic [DATA_W-1:0] s0_rdata, s1_rdata;
  logic [1:0]        s0_rresp, s1_rresp;
  logic              s0_rlast, s1_rlast;
  logic              m_arvalid, m_arready = 0;
  logic [6:0]        m_arid;
  logic [63:0]       m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic              m_rvalid = 0, m_rready;
  logic [6:0]        m_rid = 0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [1:0]        m_rresp = 0;
  logic              m_rlast = 0;
  logic [5:0]        s0_out_cnt, s1_out_cnt;
  logic              rd_err;

  cl_ddr_rd_arb #(.MAX_OUT(MAX_OUT), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s0_out_cnt(s0_out_cnt), .s1_out_cnt(s1_out_cnt), .rd_err(rd_err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [6:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  ar_t  exp_q[$];
  logic tie_q[$];
  int   n_cmp = 0, n_bad = 0, n_ar = 0;

  bit exp_hold, exp_last, exp_err;
  int exp_cnt0, exp_cnt1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_payload(input bit src);
    if (!src) begin
      s0_arid = 6'($urandom_range(0, 63)); s0_araddr = {$urandom, $urandom};
      s0_arlen = 8'($urandom); s0_arsize = 3'($urandom);
    end else begin
      s1_arid = 6'($urandom_range(0, 63)); s1_araddr = {$urandom, $urandom};
      s1_arlen = 8'($urandom); s1_arsize = 3'($urandom);
    end
  endtask

  // One clock: compare all outputs against the model at the negedge, then advance the model.
  task automatic tick();
    bit e0, e1, g0, g1, sel, rl0, rl1;
    @(negedge aclk);
    e0 = s0_arvalid && (exp_cnt0 < MAX_OUT);
    e1 = s1_arvalid && (exp_cnt1 < MAX_OUT);
    g0 = 0; g1 = 0;
    if (!exp_hold) begin
      if (e0 && e1) begin g0 = exp_last; g1 = !exp_last; end
      else begin g0 = e0; g1 = e1; end
    end
    check("s0_arready", s0_arready, g0);
    check("s1_arready", s1_arready, g1);
    check("m_arvalid", m_arvalid, exp_hold);
    if (exp_hold && exp_q.size() > 0) begin
      check("m_arid", m_arid, exp_q[0].id);
      check("m_araddr", m_araddr, exp_q[0].addr);
      check("m_arlen", m_arlen, exp_q[0].len);
      check("m_arsize", m_arsize, exp_q[0].size);
    end
    check("s0_out_cnt", s0_out_cnt, exp_cnt0);
    check("s1_out_cnt", s1_out_cnt, exp_cnt1);
    check("rd_err", rd_err, exp_err);
    sel = m_rid[6];
    check("s0_rvalid", s0_rvalid, m_rvalid && !sel);
    check("s1_rvalid", s1_rvalid, m_rvalid && sel);
    if (m_rvalid) begin
      check("m_rready", m_rready, sel ? s1_rready : s0_rready);
      check("r_rid", sel ? s1_rid : s0_rid, m_rid[5:0]);
      check("r_rdata", sel ? s1_rdata[63:0] : s0_rdata[63:0], m_rdata[63:0]);
      check("r_rlast", sel ? s1_rlast : s0_rlast, m_rlast);
      check("r_rresp", sel ? s1_rresp : s0_rresp, m_rresp);
    end
    rl0 = m_rvalid && m_rlast && !sel && s0_rready;
    rl1 = m_rvalid && m_rlast && sel && s1_rready;
    if (exp_hold && m_arready) begin
      if (tie_q.size() > 0) check("tie_order", m_arid[6], tie_q.pop_front());
      void'(exp_q.pop_front());
      exp_hold = 0;
      n_ar++;
    end
    if (g0) begin exp_q.push_back({1'b0, s0_arid, s0_araddr, s0_arlen, s0_arsize}); exp_hold = 1; exp_last = 0; end
    if (g1) begin exp_q.push_back({1'b1, s1_arid, s1_araddr, s1_arlen, s1_arsize}); exp_hold = 1; exp_last = 1; end
    if ((rl0 && exp_cnt0 == 0) || (rl1 && exp_cnt1 == 0)) exp_err = 1;
    if (g0 && !rl0) exp_cnt0++; else if (rl0 && !g0 && exp_cnt0 > 0) exp_cnt0--;
    if (g1 && !rl1) exp_cnt1++; else if (rl1 && !g1 && exp_cnt1 > 0) exp_cnt1--;
    @(posedge aclk); #1;
    if (g0) new_payload(0);
    if (g1) new_payload(1);
  endtask

  task automatic r_beat(input logic [6:0] id, input logic last);
    m_rvalid = 1; m_rid = id; m_rlast = last; m_rresp = 2'($urandom);
    for (int i = 0; i < DATA_W / 32; i++) m_rdata[32*i +: 32] = $urandom;
    tick();
    m_rvalid = 0; m_rlast = 0;
  endtask

  // Asserts reset immediately (asynchronously), checks the reset state, releases away from the clock edge.
  task automatic do_reset();
    aresetn = 0;
    exp_q.delete(); tie_q.delete();
    exp_hold = 0; exp_last = 1; exp_err = 0; exp_cnt0 = 0; exp_cnt1 = 0;
    #1;
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_s0_cnt", s0_out_cnt, 0);
    check("rst_s1_cnt", s1_out_cnt, 0);
    check("rst_rd_err", rd_err, 0);
    s0_arvalid = 0; s1_arvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    s0_rready = 1; s1_rready = 1;
    @(negedge aclk); aresetn = 1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ar_start;
    new_payload(0); new_payload(1);
    #12;
    do_reset();

    // Tie from reset: s0, s1, s0, s1 with one AR every two cycles.
    tie_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
    ar_start = n_ar;
    repeat (8) tick();
    check("tie_ar_count", n_ar - ar_start, 4);
    check("tie_list_done", tie_q.size(), 0);
    s0_arvalid = 0; s1_arvalid = 0;
    tick();
    r_beat(7'h00, 1); r_beat(7'h00, 1);
    r_beat(7'h40, 0); r_beat(7'h40, 1); r_beat(7'h40, 1);
    check("tie_drained_cnt0", s0_out_cnt, 0);

    // Stall: AR held stable for five cycles with m_arready low.
    s0_arvalid = 1; m_arready = 0;
    tick();
    s0_arvalid = 0;
    repeat (5) tick();
    check("stall_still_valid", m_arvalid, 1);
    m_arready = 1;
    ar_start = n_ar;
    tick();
    check("stall_ar_done", n_ar - ar_start, 1);
    tick();

    // Limit: s1 saturates at MAX_OUT, s0 is still served, one rlast reopens s1.
    do_reset();
    s1_arvalid = 1; m_arready = 1;
    for (int i = 0; i < 40 && exp_cnt1 < MAX_OUT; i++) tick();
    repeat (3) tick();
    check("limit_cnt", s1_out_cnt, MAX_OUT);
    check("limit_blocked", s1_arready, 0);
    s0_arvalid = 1; #1;
    check("limit_s0_granted", s0_arready, 1);
    tick();
    s0_arvalid = 0;
    tick();
    r_beat(7'h45, 1);
    check("limit_cnt_dec", s1_out_cnt, MAX_OUT - 1);
    check("limit_s1_regrant", s1_arready, 1);
    tick();
    s1_arvalid = 0;
    repeat (2) tick();

    // Simultaneous AR and rlast on s0 with count 3.
    do_reset();
    s0_arvalid = 1; m_arready = 1;
    for (int i = 0; i < 20 && exp_cnt0 < 3; i++) tick();
    s0_arvalid = 0;
    repeat (2) tick();
    check("simul_pre_cnt", s0_out_cnt, 3);
    s0_arvalid = 1; m_rvalid = 1; m_rid = 7'h05; m_rlast = 1;
    tick();
    s0_arvalid = 0; m_rvalid = 0; m_rlast = 0;
    check("simul_cnt", s0_out_cnt, 3);
    repeat (2) tick();

    // Error: rlast for s1 with nothing outstanding; sticky until reset.
    do_reset();
    r_beat(7'h40, 1);
    check("err_set", rd_err, 1);
    check("err_cnt", s1_out_cnt, 0);
    repeat (3) tick();
    check("err_sticky", rd_err, 1);
    do_reset();
    check("err_cleared", rd_err, 0);

    // Mid-operation reset while holding an AR; first tie afterwards goes to s0.
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 0;
    repeat (3) tick();
    check("midop_hold", m_arvalid, 1);
    #2;
    do_reset();
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1; #1;
    check("midop_first_s0", s0_arready, 1);
    tie_q = '{1'b0, 1'b1};
    repeat (4) tick();
    check("midop_tie_done", tie_q.size(), 0);
    s0_arvalid = 0; s1_arvalid = 0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
